// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end with one-word holding register
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             word_done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;

    logic last_bit;
    logic load;
    logic accept;

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    assign load     = hold_valid_q && ((state_q == IDLE) || last_bit);
    // Ready comes only from registered state so ser_out never sees a combinational path from in_valid.
    assign in_ready = !reset && (!hold_valid_q || load);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;

        if (accept) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end

        if (load) begin
            sh_d    = hold_data_q;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                sh_d    = IDLE_WORD;
                cnt_d   = '0;
            end else begin
                sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], IDLE_BIT} : {IDLE_BIT, sh_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sh_q         <= IDLE_WORD;
            cnt_q        <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign ser_out    = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign ser_active = (state_q == SHIFT);
    assign word_done  = last_bit;
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - table-driven directed bench for bit_serializer
module tb_bit_serializer;
    logic clk;
    logic reset;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       ser0, ser1, ser2;
    logic       act0, act1, act2;
    logic       done0, done1, done2;

    int checks = 0;
    int errors = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
        .ser_out(ser0), .ser_active(act0), .word_done(done0));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
        .ser_out(ser1), .ser_active(act1), .word_done(done1));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
        .clk(clk), .reset(reset), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
        .ser_out(ser2), .ser_active(act2), .word_done(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       ser;
        logic       act;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [7:0] d,
                       input logic rdy, input logic ser, input logic act, input logic done);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.rdy = rdy; r.ser = ser; r.act = act; r.done = done;
        vecs.push_back(r);
    endtask

    // Eight shifting cycles of word w, MSB first; with a full hold slot ready only rises on the last bit.
    task automatic add_word(input logic [7:0] w, input logic v, input logic [7:0] vd, input logic hold_full);
        for (int i = 0; i < 8; i++)
            add(1'b0, v, vd, hold_full ? (i == 7) : 1'b1, w[7-i], 1'b1, (i == 7));
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        v0 = 0; v1 = 0; v2 = 0; d0 = 0; d1 = 0; d2 = 0;
        repeat (2) @(posedge clk);

        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 8'hA5, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add_word(8'hA5, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(1, 1, 8'h55, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 8'hA5, 1, 0, 0, 0);
        add(0, 1, 8'h3C, 1, 0, 0, 0);
        add_word(8'hA5, 1, 8'hF0, 1);
        add_word(8'h3C, 0, 8'h00, 1);
        add_word(8'hF0, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 1, 8'hFF, 1, 0, 0, 0);
        add(0, 1, 8'h81, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 1, 1, 0);
        add(1, 1, 8'h55, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) add(0, 0, 8'h00, 1, 0, 0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            reset = vecs[k].rst; v0 = vecs[k].v; d0 = vecs[k].d;
            #1;
            check($sformatf("row%0d in_ready", k), rdy0, vecs[k].rdy);
            check($sformatf("row%0d ser_out", k), ser0, vecs[k].ser);
            check($sformatf("row%0d ser_active", k), act0, vecs[k].act);
            check($sformatf("row%0d word_done", k), done0, vecs[k].done);
        end
        @(negedge clk);
        reset = 1'b0; v0 = 1'b0;

        // LSB-first instance sends 0x01.
        @(negedge clk);
        v1 = 1'b1; d1 = 8'h01;
        #1 check("lsb accept ready", rdy1, 1'b1);
        @(negedge clk);
        v1 = 1'b0; d1 = 8'h00;
        #1 check("lsb load idle", act1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("lsb bit%0d ser_out", i), ser1, (i == 0));
            check($sformatf("lsb bit%0d ser_active", i), act1, 1'b1);
            check($sformatf("lsb bit%0d word_done", i), done1, (i == 7));
        end
        @(negedge clk);
        #1;
        check("lsb after ser_out", ser1, 1'b0);
        check("lsb after ser_active", act1, 1'b0);

        // Idle-high instance never received a word.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle1 c%0d ser_out", i), ser2, 1'b1);
            check($sformatf("idle1 c%0d ser_active", i), act2, 1'b0);
            check($sformatf("idle1 c%0d word_done", i), done2, 1'b0);
        end
        check("idle1 in_ready", rdy2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
